// File: rtl/cfu_cmd_arbiter_if.sv
// cfu_cmd_arbiter_if
//   One Cfu cmd/rsp link: a command carrying a function ID and two operands,
//   and a response carrying one result. cmd_lock asks the arbiter to keep the
//   grant after this transaction; it is meaningless on the downstream link.
//
//   master : issues commands (drives cmd_*, cmd_lock, rsp_ready)
//   slave  : accepts commands and returns responses (drives cmd_ready, rsp_*)
interface cfu_cmd_arbiter_if #(
    parameter int FUNC_W = 10,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [FUNC_W-1:0] cmd_payload_function_id;
    logic [DATA_W-1:0] cmd_payload_inputs_0;
    logic [DATA_W-1:0] cmd_payload_inputs_1;
    logic              cmd_lock;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_payload_outputs_0;

    modport master (
        output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
               cmd_payload_inputs_1, cmd_lock, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_payload_outputs_0
    );

    modport slave (
        input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
               cmd_payload_inputs_1, cmd_lock, rsp_ready,
        output cmd_ready, rsp_valid, rsp_payload_outputs_0
    );
endinterface

// File: rtl/cfu_cmd_arbiter.sv
// cfu_cmd_arbiter
//   Shares one Cfu between two requesters. Grants round-robin (m0 first after
//   reset), registers the winning command, issues it downstream and routes
//   the response back to the issuing requester only. A requester may keep the
//   grant across several transactions with cmd_lock, up to LOCK_MAX in a row.
//
// Ports
//   clk    : sole clock, rising edge
//   reset  : asynchronous, active-low
//   m0, m1 : requester links (slave side)
//   cfu    : downstream Cfu link (master side)
//   busy   : a transaction is in flight
//   owner  : requester of the current / last grant
module cfu_cmd_arbiter #(
    parameter int FUNC_W   = 10,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic                clk,
    input  logic                reset,
    cfu_cmd_arbiter_if.slave    m0,
    cfu_cmd_arbiter_if.slave    m1,
    cfu_cmd_arbiter_if.master   cfu,
    output logic                busy,
    output logic                owner
);
    localparam int                CNT_W     = $clog2(LOCK_MAX + 1);
    // lock_cnt + 1 < LOCK_MAX  <=>  lock_cnt < LOCK_MAX - 1, without overflow
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state;
    logic              last_grant;
    logic              locked;
    logic              lock_owner;
    logic [CNT_W-1:0]  lock_cnt;
    logic              cap_lock;
    logic [FUNC_W-1:0] fid_q;
    logic [DATA_W-1:0] in0_q;
    logic [DATA_W-1:0] in1_q;

    logic              grant_valid;
    logic              grant_sel;

    // Arbitration is only live in IDLE, which also enforces one outstanding
    // transaction.
    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        grant_valid = 1'b0;
        grant_sel   = 1'b0;
        if (state == IDLE) begin
            if (locked) begin
                grant_sel   = lock_owner;
                grant_valid = lock_owner ? m1.cmd_valid : m0.cmd_valid;
            end else if (m0.cmd_valid && m1.cmd_valid) begin
                grant_valid = 1'b1;
                grant_sel   = ~last_grant;
            end else if (m0.cmd_valid) begin
                grant_valid = 1'b1;
                grant_sel   = 1'b0;
            end else if (m1.cmd_valid) begin
                grant_valid = 1'b1;
                grant_sel   = 1'b1;
            end
        end
    end

    // Gated with reset so cmd_ready reads 0 while reset is held even though
    // the state is already IDLE.
    assign m0.cmd_ready = reset && grant_valid && !grant_sel;
    assign m1.cmd_ready = reset && grant_valid &&  grant_sel;

    assign m0.rsp_valid = (state == WAIT) && !owner && cfu.rsp_valid;
    assign m1.rsp_valid = (state == WAIT) &&  owner && cfu.rsp_valid;
    assign m0.rsp_payload_outputs_0 = cfu.rsp_payload_outputs_0;
    assign m1.rsp_payload_outputs_0 = cfu.rsp_payload_outputs_0;
    assign cfu.rsp_ready = (state == WAIT) && (owner ? m1.rsp_ready : m0.rsp_ready);

    assign cfu.cmd_valid               = (state == ISSUE);
    assign cfu.cmd_payload_function_id = fid_q;
    assign cfu.cmd_payload_inputs_0    = in0_q;
    assign cfu.cmd_payload_inputs_1    = in1_q;
    assign cfu.cmd_lock                = 1'b0;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            locked     <= 1'b0;
            lock_owner <= 1'b0;
            lock_cnt   <= '0;
            cap_lock   <= 1'b0;
            // NOTE: the payload registers are reset because they drive the cfu bus directly.
            fid_q      <= '0;
            in0_q      <= '0;
            in1_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner      <= grant_sel;
                        last_grant <= grant_sel;
                        cap_lock   <= grant_sel ? m1.cmd_lock : m0.cmd_lock;
                        fid_q      <= grant_sel ? m1.cmd_payload_function_id : m0.cmd_payload_function_id;
                        in0_q      <= grant_sel ? m1.cmd_payload_inputs_0 : m0.cmd_payload_inputs_0;
                        in1_q      <= grant_sel ? m1.cmd_payload_inputs_1 : m0.cmd_payload_inputs_1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cfu.cmd_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cfu.rsp_valid && cfu.rsp_ready) begin
                        state <= IDLE;
                        if (!cap_lock) begin
                            locked   <= 1'b0;
                            lock_cnt <= '0;
                        end else if (lock_cnt < LOCK_LAST) begin
                            locked     <= 1'b1;
                            lock_owner <= owner;
                            lock_cnt   <= lock_cnt + 1'b1;
                        end else begin
                            // Forced release: the other requester wins the next tie.
                            locked     <= 1'b0;
                            lock_cnt   <= '0;
                            last_grant <= owner;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cfu_cmd_arbiter.sv
// tb_cfu_cmd_arbiter
//   Directed scenarios followed by a randomized phase. A transaction-level
//   reference model (grant rules, lock bookkeeping, per-requester result
//   queues) and a small Cfu model live in the bench. LOCK_MAX is 3 here so
//   that a three-command locked sequence and the forced release both occur
//   with one instance.
module tb_cfu_cmd_arbiter;
    localparam int FUNC_W   = 10;
    localparam int DATA_W   = 32;
    localparam int LOCK_MAX = 3;

    localparam logic [9:0] F_ADD  = 10'h007;
    localparam logic [9:0] F_SUB  = 10'h107;
    localparam logic [9:0] F_MUL  = 10'h207;
    localparam logic [9:0] F_MCLR = 10'h008;
    localparam logic [9:0] F_MACC = 10'h108;

    typedef struct packed {
        logic [9:0]  fid;
        logic [31:0] a;
        logic [31:0] b;
        logic        lock;
    } cmd_t;

    logic clk = 1'b0;
    logic reset;
    logic busy, owner;
    always #5 clk = ~clk;

    cfu_cmd_arbiter_if #(.FUNC_W(FUNC_W), .DATA_W(DATA_W)) m0_if ();
    cfu_cmd_arbiter_if #(.FUNC_W(FUNC_W), .DATA_W(DATA_W)) m1_if ();
    cfu_cmd_arbiter_if #(.FUNC_W(FUNC_W), .DATA_W(DATA_W)) cfu_if ();

    cfu_cmd_arbiter #(.FUNC_W(FUNC_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset(reset), .m0(m0_if), .m1(m1_if), .cfu(cfu_if),
        .busy(busy), .owner(owner)
    );

    // Stimulus drives
    logic        drv_valid[2];
    cmd_t        drv_cmd[2];
    logic        drv_rsp_ready[2];
    logic        drv_cfu_cmd_ready;
    logic        drv_cfu_rsp_valid;
    logic [31:0] drv_cfu_rsp;

    assign m0_if.cmd_valid               = drv_valid[0];
    assign m0_if.cmd_payload_function_id = drv_cmd[0].fid;
    assign m0_if.cmd_payload_inputs_0    = drv_cmd[0].a;
    assign m0_if.cmd_payload_inputs_1    = drv_cmd[0].b;
    assign m0_if.cmd_lock                = drv_cmd[0].lock;
    assign m0_if.rsp_ready               = drv_rsp_ready[0];
    assign m1_if.cmd_valid               = drv_valid[1];
    assign m1_if.cmd_payload_function_id = drv_cmd[1].fid;
    assign m1_if.cmd_payload_inputs_0    = drv_cmd[1].a;
    assign m1_if.cmd_payload_inputs_1    = drv_cmd[1].b;
    assign m1_if.cmd_lock                = drv_cmd[1].lock;
    assign m1_if.rsp_ready               = drv_rsp_ready[1];
    assign cfu_if.cmd_ready              = drv_cfu_cmd_ready;
    assign cfu_if.rsp_valid              = drv_cfu_rsp_valid;
    assign cfu_if.rsp_payload_outputs_0  = drv_cfu_rsp;

    logic        obs_cmd_ready[2];
    logic        obs_rsp_valid[2];
    logic [31:0] obs_rsp[2];
    assign obs_cmd_ready[0] = m0_if.cmd_ready;
    assign obs_cmd_ready[1] = m1_if.cmd_ready;
    assign obs_rsp_valid[0] = m0_if.rsp_valid;
    assign obs_rsp_valid[1] = m1_if.rsp_valid;
    assign obs_rsp[0]       = m0_if.rsp_payload_outputs_0;
    assign obs_rsp[1]       = m1_if.rsp_payload_outputs_0;

    // Reference model: one transaction record plus lock bookkeeping
    logic        m_busy, m_issued, m_owner, m_last;
    logic        m_locked, m_lock_owner;
    int          m_cnt;
    cmd_t        m_cap;
    logic [31:0] ref_acc;
    cmd_t        q[2][$];
    logic [31:0] exp_q[2][$];

    // Cfu model
    logic        c_has;
    int          c_delay;
    int          c_max_delay;
    logic [31:0] c_result;
    logic [31:0] c_acc;

    // Stimulus policy and observation logs
    logic        present_rand, rsp_rand, cfu_rand;
    int          block[2];
    int          stall_seen;
    logic        obs_log[$];
    logic [31:0] last_rsp[2];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic cmd_t mk(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b, input logic l);
        cmd_t c;
        c.fid = f; c.a = a; c.b = b; c.lock = l;
        return c;
    endfunction

    // Cfu behaviour: result of a command given the accumulator before it.
    function automatic logic [31:0] alu(input cmd_t c, input logic [31:0] acc_in, output logic [31:0] acc_out);
        acc_out = acc_in;
        case (c.fid)
            F_ADD:   return c.a + c.b;
            F_SUB:   return c.a - c.b;
            F_MUL:   return c.a * c.b;
            F_MCLR:  begin acc_out = 32'd0; return 32'd0; end
            F_MACC:  begin acc_out = acc_in + c.a * c.b; return acc_out; end
            default: return c.a ^ c.b;
        endcase
    endfunction

    function automatic cmd_t rnd_cmd(input logic l);
        logic [9:0] f;
        case ($urandom_range(0, 4))
            0:       f = F_ADD;
            1:       f = F_SUB;
            2:       f = F_MUL;
            3:       f = F_MCLR;
            default: f = F_MACC;
        endcase
        return mk(f, $urandom, ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 255)), l);
    endfunction

    task automatic reset_model();
        m_busy = 1'b0; m_issued = 1'b0; m_owner = 1'b0; m_last = 1'b1;
        m_locked = 1'b0; m_lock_owner = 1'b0; m_cnt = 0; m_cap = '0;
        ref_acc = 32'd0; c_acc = 32'd0; c_has = 1'b0; c_delay = 0; c_result = 32'd0;
        for (int n = 0; n < 2; n++) begin
            q[n].delete(); exp_q[n].delete(); block[n] = 0;
        end
    endtask

    task automatic idle_drive();
        for (int n = 0; n < 2; n++) begin
            drv_valid[n] = 1'b0; drv_cmd[n] = '0; drv_rsp_ready[n] = 1'b0;
        end
        drv_cfu_cmd_ready = 1'b0; drv_cfu_rsp_valid = 1'b0; drv_cfu_rsp = 32'd0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},          busy, 0);
        check({tag, "_owner"},         owner, 0);
        check({tag, "_m0_cmd_ready"},  obs_cmd_ready[0], 0);
        check({tag, "_m1_cmd_ready"},  obs_cmd_ready[1], 0);
        check({tag, "_m0_rsp_valid"},  obs_rsp_valid[0], 0);
        check({tag, "_m1_rsp_valid"},  obs_rsp_valid[1], 0);
        check({tag, "_cfu_cmd_valid"}, cfu_if.cmd_valid, 0);
        check({tag, "_cfu_rsp_ready"}, cfu_if.rsp_ready, 0);
        check({tag, "_cfu_fid"},       cfu_if.cmd_payload_function_id, 0);
        check({tag, "_cfu_ops"},       {cfu_if.cmd_payload_inputs_0, cfu_if.cmd_payload_inputs_1}, 0);
        check({tag, "_cfu_lock"},      cfu_if.cmd_lock, 0);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        idle_drive();
        reset_model();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One clock cycle: drive at the falling edge, check 1 ns later, then
    // advance the models to what the next rising edge does.
    task automatic step();
        logic        w_ok, w, hs_rsp, hs_cmd;
        logic        ev[2];
        cmd_t        c;
        logic [31:0] acc_tmp, r;

        for (int n = 0; n < 2; n++) begin
            if (q[n].size() > 0 && (!present_rand || $urandom_range(0, 3) != 0)) begin
                drv_valid[n] = 1'b1;
                drv_cmd[n]   = q[n][0];
            end else begin
                drv_valid[n] = 1'b0;
                drv_cmd[n]   = mk(10'($urandom), $urandom, $urandom, 1'($urandom));
            end
        end
        drv_cfu_cmd_ready = cfu_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        drv_cfu_rsp_valid = c_has && (c_delay == 0);
        drv_cfu_rsp       = drv_cfu_rsp_valid ? c_result : $urandom;
        for (int n = 0; n < 2; n++)
            ev[n] = m_busy && m_issued && (m_owner == 1'(n)) && drv_cfu_rsp_valid;
        for (int n = 0; n < 2; n++) begin
            if (block[n] > 0 && ev[n]) begin
                drv_rsp_ready[n] = 1'b0;
                block[n]--;
            end else begin
                drv_rsp_ready[n] = rsp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        #1;

        w_ok = 1'b0; w = 1'b0;
        if (m_locked) begin
            w = m_lock_owner; w_ok = drv_valid[w];
        end else if (drv_valid[0] && drv_valid[1]) begin
            w = ~m_last; w_ok = 1'b1;
        end else if (drv_valid[0]) begin
            w = 1'b0; w_ok = 1'b1;
        end else if (drv_valid[1]) begin
            w = 1'b1; w_ok = 1'b1;
        end
        if (m_busy) w_ok = 1'b0;

        check("busy", busy, m_busy);
        check("owner", owner, m_owner);
        for (int n = 0; n < 2; n++)
            check($sformatf("m%0d_cmd_ready", n), obs_cmd_ready[n], w_ok && (w == 1'(n)));
        check("cfu_cmd_valid", cfu_if.cmd_valid, m_busy && !m_issued);
        if (m_busy && !m_issued) begin
            check("cfu_cmd_fid", cfu_if.cmd_payload_function_id, m_cap.fid);
            check("cfu_cmd_ops", {cfu_if.cmd_payload_inputs_0, cfu_if.cmd_payload_inputs_1}, {m_cap.a, m_cap.b});
        end
        check("cfu_rsp_ready", cfu_if.rsp_ready, m_busy && m_issued && drv_rsp_ready[m_owner]);
        for (int n = 0; n < 2; n++) begin
            check($sformatf("m%0d_rsp_valid", n), obs_rsp_valid[n], ev[n]);
            if (ev[n]) check($sformatf("m%0d_rsp_payload", n), obs_rsp[n], c_result);
        end

        if (obs_rsp_valid[0] && !drv_rsp_ready[0]) stall_seen++;
        if (obs_cmd_ready[0] && drv_valid[0])      obs_log.push_back(1'b0);
        else if (obs_cmd_ready[1] && drv_valid[1]) obs_log.push_back(1'b1);

        hs_rsp = ev[m_owner] && drv_rsp_ready[m_owner];
        hs_cmd = m_busy && !m_issued && drv_cfu_cmd_ready;
        if (c_has && c_delay > 0) c_delay--;
        if (hs_rsp) begin
            last_rsp[m_owner] = obs_rsp[m_owner];
            if (exp_q[m_owner].size() > 0)
                check($sformatf("m%0d_result", m_owner), obs_rsp[m_owner], exp_q[m_owner].pop_front());
            if (!m_cap.lock) begin
                m_locked = 1'b0; m_cnt = 0;
            end else if (m_cnt + 1 < LOCK_MAX) begin
                m_locked = 1'b1; m_lock_owner = m_owner; m_cnt++;
            end else begin
                m_locked = 1'b0; m_cnt = 0; m_last = m_owner;
            end
            m_busy = 1'b0;
            c_has  = 1'b0;
        end
        if (hs_cmd) begin
            c = mk(cfu_if.cmd_payload_function_id, cfu_if.cmd_payload_inputs_0, cfu_if.cmd_payload_inputs_1, 1'b0);
            c_result = alu(c, c_acc, acc_tmp);
            c_acc    = acc_tmp;
            c_has    = 1'b1;
            c_delay  = $urandom_range(0, c_max_delay);
            m_issued = 1'b1;
        end
        if (w_ok) begin
            c = q[w].pop_front();
            m_busy = 1'b1; m_issued = 1'b0; m_owner = w; m_last = w; m_cap = c;
            r = alu(c, ref_acc, acc_tmp);
            ref_acc = acc_tmp;
            exp_q[w].push_back(r);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_until_idle(input string tag, input int max_cycles);
        int k = 0;
        while ((q[0].size() > 0 || q[1].size() > 0 || m_busy) && k < max_cycles) begin
            step();
            k++;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    // Grant order bit i of e is the requester expected for the i-th accept.
    task automatic check_order(input string tag, input logic [7:0] e, input int len);
        check({tag, "_grants"}, obs_log.size(), len);
        for (int i = 0; i < len && i < obs_log.size(); i++)
            check($sformatf("%s_grant%0d", tag, i), obs_log[i], e[i]);
    endtask

    initial begin
        present_rand = 1'b0; rsp_rand = 1'b0; cfu_rand = 1'b0; c_max_delay = 0;
        stall_seen = 0; last_rsp[0] = 32'd0; last_rsp[1] = 32'd0;
        reset = 1'b0;
        idle_drive();
        reset_model();
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Single request
        obs_log.delete();
        q[0].push_back(mk(F_ADD, 32'd5, 32'd3, 1'b0));
        run_until_idle("single", 50);
        check("single_result", last_rsp[0], 32'd8);
        check_order("single", 8'b0, 1);

        // Round-robin from reset
        apply_reset();
        obs_log.delete();
        q[0].push_back(mk(F_ADD, 32'd5, 32'd3, 1'b0));
        q[1].push_back(mk(F_SUB, 32'd5, 32'd3, 1'b0));
        run_until_idle("rr1", 50);
        check("rr_m0_result", last_rsp[0], 32'd8);
        check("rr_m1_result", last_rsp[1], 32'd2);
        q[0].push_back(mk(F_ADD, 32'd5, 32'd3, 1'b0));
        q[1].push_back(mk(F_SUB, 32'd5, 32'd3, 1'b0));
        run_until_idle("rr2", 50);
        check_order("rr", 8'b1010, 4);

        // Locked MAC sequence with m1 waiting throughout
        obs_log.delete();
        q[0].push_back(mk(F_MCLR, 32'd0, 32'd0, 1'b1));
        q[0].push_back(mk(F_MACC, 32'h505, 32'h403, 1'b1));
        q[0].push_back(mk(F_MACC, 32'h505, 32'h403, 1'b0));
        q[1].push_back(mk(F_MUL, 32'd5, 32'd3, 1'b0));
        run_until_idle("lock", 80);
        check_order("lock", 8'b1000, 4);
        check("lock_m1_result", last_rsp[1], 32'd15);

        // Starvation cap: m0 always locks, m1 pending
        obs_log.delete();
        for (int i = 0; i < 6; i++) q[0].push_back(mk(F_ADD, 32'(i), 32'd100, 1'b1));
        for (int i = 0; i < 2; i++) q[1].push_back(mk(F_SUB, 32'd50, 32'(i), 1'b0));
        run_until_idle("cap", 150);
        check_order("cap", 8'b1000_1000, 8);

        // Response backpressure on m0 for 5 cycles
        stall_seen = 0;
        block[0] = 5;
        q[0].push_back(mk(F_ADD, 32'd40, 32'd2, 1'b0));
        run_until_idle("bp", 50);
        check("bp_stall_cycles", stall_seen, 5);
        check("bp_result", last_rsp[0], 32'd42);

        // Randomized traffic
        present_rand = 1'b1; rsp_rand = 1'b1; cfu_rand = 1'b1; c_max_delay = 3;
        for (int i = 0; i < 12; i++) begin
            for (int p = 0; p < 2; p++) begin
                int len;
                len = $urandom_range(1, 3);
                for (int j = 0; j < len; j++) q[p].push_back(rnd_cmd(j != len - 1));
            end
        end
        run_until_idle("random", 5000);
        present_rand = 1'b0; rsp_rand = 1'b0; cfu_rand = 1'b0; c_max_delay = 0;

        // Reset while m1's response is pending in WAIT
        apply_reset();
        block[1] = 100;
        q[1].push_back(mk(F_ADD, 32'd7, 32'd9, 1'b0));
        for (int k = 0; k < 20 && !(m_busy && m_issued); k++) step();
        drv_cfu_rsp_valid = 1'b1;
        drv_cfu_rsp       = 32'd16;
        drv_rsp_ready[1]  = 1'b0;
        drv_valid[0]      = 1'b1;
        drv_cmd[0]        = mk(F_ADD, 32'd1, 32'd1, 1'b0);
        #1;
        check("pre_reset_m1_rsp_valid", obs_rsp_valid[1], 1);
        reset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        idle_drive();
        reset_model();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        obs_log.delete();
        q[1].push_back(mk(F_MUL, 32'd6, 32'd7, 1'b0));
        run_until_idle("after_reset", 50);
        check("after_reset_result", last_rsp[1], 32'd42);
        check_order("after_reset", 8'b1, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
